if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 152 +++++++++++++++
 tb/tb_if_stage.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC sequencing, imem handshake, redirect/drop tracking and IF/ID register.
// Optional fetch/bubble performance counters are compiled in when IF_PERF_CNT_EN is defined.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INS  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  pc_src,
    input  logic [31:0] branch,
    input  logic [31:0] rs,
    input  logic [27:0] offset28,
    input  logic        if_flush,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic [31:0] pc_4_out,
    output logic [31:0] ins_out,
    output logic        ins_valid
`ifdef IF_PERF_CNT_EN
   ,output logic [31:0] fetch_cnt,
    output logic [31:0] bubble_cnt
`endif
);

    // state | meaning
    // IDLE  | one cycle after reset release, no request issued
    // FETCH | requesting imem at pc; responses go to IF/ID
    // DROP  | redirect taken while a request was outstanding; next response is discarded
    typedef enum logic [1:0] {IDLE, FETCH, DROP} state_t;

    state_t      state, state_d;
    logic [31:0] pc, pc_d;
    logic [31:0] redir, redir_d;
    logic        hold_valid, hold_valid_d;
    logic [31:0] hold_data, hold_data_d;

    logic        ld_ifid;
    logic        ld_valid;
    logic [31:0] ld_ins;
    logic        redirect;
    logic        resp;
    logic [31:0] rsp_data;
    logic [31:0] target;
    logic [31:0] pc_inc;

    // A response captured during stall stands in for the next ack, so no new request is issued.
    assign imem_req  = (state != IDLE) && !hold_valid;
    assign imem_addr = pc;

    always_comb begin
        redirect = (pc_src != 2'b00);
        resp     = hold_valid || (imem_req && imem_ack);
        rsp_data = hold_valid ? hold_data : imem_data;
        pc_inc   = pc + 32'd4;
        case (pc_src)
            2'b01:   target = branch;
            2'b10:   target = {pc_4_out[31:28], offset28};
            default: target = rs;
        endcase
    end

    always_comb begin
        state_d      = state;
        pc_d         = pc;
        redir_d      = redir;
        hold_valid_d = hold_valid;
        hold_data_d  = hold_data;
        ld_ifid      = 1'b0;
        ld_valid     = 1'b0;
        ld_ins       = NOP_INS;

        if (state == IDLE) begin
            state_d = FETCH;
        end else if (stall) begin
            if (imem_req && imem_ack) begin
                hold_valid_d = 1'b1;
                hold_data_d  = imem_data;
            end
        end else begin
            hold_valid_d = 1'b0;
            ld_ifid      = 1'b1;
            case (state)
                FETCH: begin
                    if (redirect) begin
                        if (resp) begin
                            pc_d = target;
                        end else begin
                            redir_d = target;
                            state_d = DROP;
                        end
                    end else if (if_flush) begin
                        if (resp) pc_d = pc_inc;
                    end else if (resp) begin
                        ld_valid = 1'b1;
                        ld_ins   = rsp_data;
                        pc_d     = pc_inc;
                    end
                end
                DROP: begin
                    if (resp) begin
                        pc_d    = redirect ? target : redir;
                        state_d = FETCH;
                    end else if (redirect) begin
                        redir_d = target;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            redir      <= 32'h0;
            hold_valid <= 1'b0;
            hold_data  <= 32'h0;
            pc_4_out   <= 32'h0;
            ins_out    <= NOP_INS;
            ins_valid  <= 1'b0;
        end else begin
            state      <= state_d;
            pc         <= pc_d;
            redir      <= redir_d;
            hold_valid <= hold_valid_d;
            hold_data  <= hold_data_d;
            if (ld_ifid) begin
                ins_valid <= ld_valid;
                ins_out   <= ld_ins;
                // Bubbles leave pc_4_out pointing at the last real instruction.
                if (ld_valid) pc_4_out <= pc;
            end
        end
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_cnt  <= 32'h0;
            bubble_cnt <= 32'h0;
        end else if (ld_ifid) begin
            if (ld_valid) fetch_cnt  <= fetch_cnt + 32'd1;
            else          bubble_cnt <= bubble_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: one cycle per table row, plus reset and counter sequences.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int NV = 31;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  pc_src = 2'b00;
    logic [31:0] branch = 32'h0;
    logic [31:0] rs = 32'h0;
    logic [27:0] offset28 = 28'h0;
    logic        if_flush = 1'b0;
    logic        stall = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_data = 32'h0;
    logic [31:0] pc_4_out;
    logic [31:0] ins_out;
    logic        ins_valid;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] bubble_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int vi = -1;

    if_stage #(.RESET_PC(32'h0000_0000), .NOP_INS(NOP)) dut (
        .clk(clk), .reset(reset), .pc_src(pc_src), .branch(branch), .rs(rs),
        .offset28(offset28), .if_flush(if_flush), .stall(stall),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_data(imem_data), .pc_4_out(pc_4_out), .ins_out(ins_out),
        .ins_valid(ins_valid)
`ifdef IF_PERF_CNT_EN
       ,.fetch_cnt(fetch_cnt), .bubble_cnt(bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic [1:0]  ps;
        logic [31:0] br;
        logic [31:0] rs;
        logic [27:0] off;
        logic        fl;
        logic        ack;
        logic [31:0] d;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_v;
        logic [31:0] e_ins;
        logic [31:0] e_pc4;
    } vec_t;

    vec_t vecs[NV];

    function automatic vec_t mk(logic st, logic [1:0] ps, logic [31:0] br, logic [31:0] r,
                                logic [27:0] off, logic fl, logic ack, logic [31:0] d,
                                logic er, logic [31:0] ea, logic ev, logic [31:0] ei,
                                logic [31:0] ep);
        vec_t v;
        v.st = st; v.ps = ps; v.br = br; v.rs = r; v.off = off; v.fl = fl; v.ack = ack;
        v.d = d; v.e_req = er; v.e_addr = ea; v.e_v = ev; v.e_ins = ei; v.e_pc4 = ep;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d actual %h expected %h", name, vi, act, exp);
        end
    endtask

    task automatic drive_idle();
        stall = 1'b0; pc_src = 2'b00; branch = 32'h0; rs = 32'h0; offset28 = 28'h0;
        if_flush = 1'b0; imem_ack = 1'b0; imem_data = 32'h0;
    endtask

    initial begin
        //        st ps br            rs            off         fl ack d              req addr          v  ins           pc4
        vecs[0]  = mk(0, 0, 0,            0,            0,          0, 1, 32'h0,         0, 32'h0,         0, NOP,          0);
        vecs[1]  = mk(0, 0, 0,            0,            0,          0, 1, 32'h0,         1, 32'h0,         1, 32'h0,        32'h0);
        vecs[2]  = mk(0, 0, 0,            0,            0,          0, 1, 32'h4,         1, 32'h4,         1, 32'h4,        32'h4);
        vecs[3]  = mk(0, 0, 0,            0,            0,          0, 1, 32'h8,         1, 32'h8,         1, 32'h8,        32'h8);
        vecs[4]  = mk(0, 1, 32'h100,      0,            0,          0, 1, 32'hDEADBEEF,  1, 32'hC,         0, NOP,          0);
        vecs[5]  = mk(0, 0, 0,            0,            0,          0, 1, 32'h100,       1, 32'h100,       1, 32'h100,      32'h100);
        vecs[6]  = mk(0, 0, 0,            0,            0,          0, 0, 32'h0,         1, 32'h104,       0, NOP,          0);
        vecs[7]  = mk(0, 0, 0,            0,            0,          0, 1, 32'h104,       1, 32'h104,       1, 32'h104,      32'h104);
        vecs[8]  = mk(0, 0, 0,            0,            0,          1, 1, 32'h108,       1, 32'h108,       0, NOP,          0);
        vecs[9]  = mk(0, 0, 0,            0,            0,          1, 0, 32'h0,         1, 32'h10C,       0, NOP,          0);
        vecs[10] = mk(0, 3, 0,            32'hFFFFFFFC, 0,          0, 1, 32'hBAD,       1, 32'h10C,       0, NOP,          0);
        vecs[11] = mk(0, 0, 0,            0,            0,          0, 1, 32'hFFFFFFFC,  1, 32'hFFFFFFFC,  1, 32'hFFFFFFFC, 32'hFFFFFFFC);
        vecs[12] = mk(0, 0, 0,            0,            0,          0, 1, 32'h0,         1, 32'h0,         1, 32'h0,        32'h0);
        vecs[13] = mk(0, 3, 0,            32'h30000010, 0,          0, 1, 32'hBAD,       1, 32'h4,         0, NOP,          0);
        vecs[14] = mk(0, 0, 0,            0,            0,          0, 1, 32'hA0A0,      1, 32'h30000010,  1, 32'hA0A0,     32'h30000010);
        vecs[15] = mk(0, 2, 0,            0,            28'h0000040, 0, 0, 32'h0,        1, 32'h30000014,  0, NOP,          0);
        vecs[16] = mk(0, 0, 0,            0,            0,          0, 0, 32'h0,         1, 32'h30000014,  0, NOP,          0);
        vecs[17] = mk(0, 0, 0,            0,            0,          0, 0, 32'h0,         1, 32'h30000014,  0, NOP,          0);
        vecs[18] = mk(0, 0, 0,            0,            0,          0, 1, 32'hBAD,       1, 32'h30000014,  0, NOP,          0);
        vecs[19] = mk(0, 0, 0,            0,            0,          0, 1, 32'h40,        1, 32'h30000040,  1, 32'h40,       32'h30000040);
        vecs[20] = mk(1, 0, 0,            0,            0,          0, 1, 32'h44,        1, 32'h30000044,  1, 32'h40,       32'h30000040);
        vecs[21] = mk(1, 1, 32'h0,        0,            0,          1, 1, 32'hBAD,       0, 32'h30000044,  1, 32'h40,       32'h30000040);
        vecs[22] = mk(0, 0, 0,            0,            0,          0, 1, 32'hBAD,       0, 32'h30000044,  1, 32'h44,       32'h30000044);
        vecs[23] = mk(0, 0, 0,            0,            0,          0, 1, 32'h48,        1, 32'h30000048,  1, 32'h48,       32'h30000048);
        vecs[24] = mk(1, 0, 0,            0,            0,          0, 1, 32'h4C,        1, 32'h3000004C,  1, 32'h48,       32'h30000048);
        vecs[25] = mk(0, 1, 32'h200,      0,            0,          0, 1, 32'hBAD,       0, 32'h3000004C,  0, NOP,          0);
        vecs[26] = mk(0, 0, 0,            0,            0,          0, 1, 32'h200,       1, 32'h200,       1, 32'h200,      32'h200);
        vecs[27] = mk(0, 1, 32'h300,      0,            0,          0, 0, 32'h0,         1, 32'h204,       0, NOP,          0);
        vecs[28] = mk(0, 1, 32'h400,      0,            0,          0, 0, 32'h0,         1, 32'h204,       0, NOP,          0);
        vecs[29] = mk(0, 0, 0,            0,            0,          0, 1, 32'hBAD,       1, 32'h204,       0, NOP,          0);
        vecs[30] = mk(0, 0, 0,            0,            0,          0, 1, 32'h400,       1, 32'h400,       1, 32'h400,      32'h400);

        // Reset values
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_pc4", pc_4_out, 32'h0);
        chk("rst_ins", ins_out, NOP);
        chk("rst_valid", {31'h0, ins_valid}, 32'h0);
`ifdef IF_PERF_CNT_EN
        chk("rst_fetch_cnt", fetch_cnt, 32'h0);
        chk("rst_bubble_cnt", bubble_cnt, 32'h0);
`endif
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < NV; i++) begin
            vi = i;
            stall = vecs[i].st; pc_src = vecs[i].ps; branch = vecs[i].br; rs = vecs[i].rs;
            offset28 = vecs[i].off; if_flush = vecs[i].fl; imem_ack = vecs[i].ack;
            imem_data = vecs[i].d;
            #1;
            chk("imem_req", {31'h0, imem_req}, {31'h0, vecs[i].e_req});
            chk("imem_addr", imem_addr, vecs[i].e_addr);
            @(posedge clk);
            #1;
            chk("ins_valid", {31'h0, ins_valid}, {31'h0, vecs[i].e_v});
            chk("ins_out", ins_out, vecs[i].e_ins);
            if (vecs[i].e_v) chk("pc_4_out", pc_4_out, vecs[i].e_pc4);
            @(negedge clk);
        end

        // Reset mid-fetch: outstanding request abandoned, late ack ignored
        vi = 100;
        drive_idle();
        #1;
        chk("mid_req", {31'h0, imem_req}, 32'h1);
        chk("mid_addr", imem_addr, 32'h404);
        reset = 1'b0;
        #1;
        chk("mid_rst_req", {31'h0, imem_req}, 32'h0);
        chk("mid_rst_addr", imem_addr, 32'h0);
        chk("mid_rst_valid", {31'h0, ins_valid}, 32'h0);
        chk("mid_rst_ins", ins_out, NOP);
        @(negedge clk);
        reset = 1'b1;
        imem_ack = 1'b1; imem_data = 32'hBAD;
        @(posedge clk);
        #1;
        chk("late_ack_valid", {31'h0, ins_valid}, 32'h0);
        @(negedge clk);
        imem_data = 32'h0;
        #1;
        chk("post_rst_req", {31'h0, imem_req}, 32'h1);
        chk("post_rst_addr", imem_addr, 32'h0);
        @(posedge clk);
        #1;
        chk("post_rst_valid", {31'h0, ins_valid}, 32'h1);
        chk("post_rst_ins", ins_out, 32'h0);

`ifdef IF_PERF_CNT_EN
        // Ten clean fetches then one flush
        vi = 200;
        @(negedge clk);
        drive_idle();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        imem_ack = 1'b1;
        for (int k = 0; k < 11; k++) begin
            imem_data = 32'h1000 + k;
            @(negedge clk);
        end
        if_flush = 1'b1;
        @(posedge clk);
        #1;
        chk("fetch_cnt", fetch_cnt, 32'd10);
        chk("bubble_cnt", bubble_cnt, 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
